vga_timing_multimode: RTL and testbench

- Runtime-selectable VGA timing generator. Produces hcount/vcount, sync and blank signals for one of NUM_MODES video modes held in a package table.
- Mode changes are requested by a req/ack handshake and take effect only at a frame boundary, so no frame is ever torn.
- Sits at the head of the video pipeline and drives the draw/overlay chain. The pixel clock is supplied externally per mode; this block only counts cycles.

---
 rtl/vga_mode_pkg.sv | 46 ++++
 rtl/vga_timing_multimode_ctrl.sv | 71 +++++++
 rtl/vga_timing_multimode.sv | 156 +++++++++++++++
 tb/tb_vga_timing_multimode.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mode_pkg.sv
// rtl/vga_mode_pkg.sv - video mode table, controller state type and table sanity helpers
package vga_mode_pkg;

  localparam int VGA_TABLE_DEPTH = 4;

  typedef struct packed {
    logic [15:0] h_total;
    logic [15:0] h_blank_start;
    logic [15:0] h_sync_start;
    logic [15:0] h_sync_end;
    logic [15:0] v_total;
    logic [15:0] v_blank_start;
    logic [15:0] v_sync_start;
    logic [15:0] v_sync_end;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  typedef vga_mode_t [VGA_TABLE_DEPTH-1:0] vga_mode_tbl_t;

  typedef enum logic {
    CTRL_IDLE    = 1'b0,
    CTRL_PENDING = 1'b1
  } vga_ctrl_state_t;

  localparam vga_mode_t VGA_MODE_TABLE [VGA_TABLE_DEPTH] = '{
    '{16'd1344, 16'd1024, 16'd1048, 16'd1184, 16'd806, 16'd768, 16'd771, 16'd777, 1'b0, 1'b0},
    '{16'd1056, 16'd800,  16'd840,  16'd968,  16'd628, 16'd600, 16'd601, 16'd605, 1'b1, 1'b1},
    '{16'd800,  16'd640,  16'd656,  16'd752,  16'd525, 16'd480, 16'd490, 16'd492, 1'b0, 1'b0},
    '{16'd1344, 16'd1024, 16'd1048, 16'd1184, 16'd806, 16'd768, 16'd771, 16'd777, 1'b0, 1'b0}
  };

  // Packed view of the table so it can be passed as a module parameter.
  localparam vga_mode_tbl_t VGA_MODE_TABLE_P = {
    VGA_MODE_TABLE[3], VGA_MODE_TABLE[2], VGA_MODE_TABLE[1], VGA_MODE_TABLE[0]
  };

  function automatic logic val_below(input logic [15:0] v, input int lim);
    return 32'(v) < lim;
  endfunction

  function automatic logic total_fits(input logic [15:0] v, input int lim);
    return (v != 16'd0) && (32'(v) <= lim);
  endfunction

endpackage

// File: rtl/vga_timing_multimode_ctrl.sv
// rtl/vga_timing_multimode_ctrl.sv - mode request validation, pending slot and frame-boundary switch
module vga_mode_ctrl
  import vga_mode_pkg::*;
#(
  parameter int NUM_MODES    = 3,
  parameter int DEFAULT_MODE = 0,
  parameter int MODE_W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_req_i,
  input  logic [MODE_W-1:0] mode_sel_i,
  input  logic              frame_boundary_i,
  output logic [MODE_W-1:0] mode_active_o,
  output logic [MODE_W-1:0] mode_next_o,
  output logic              mode_busy_o,
  output logic              mode_ack_o,
  output logic              mode_err_o
);

  vga_ctrl_state_t   state_q, state_d;
  logic [MODE_W-1:0] pending_q, pending_d;
  logic [MODE_W-1:0] active_q, active_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              req_ok;

  assign req_ok = mode_req_i && (32'(mode_sel_i) < NUM_MODES);

  // The switch is evaluated before the new request so that a request landing
  // on the boundary cycle re-arms the slot for the following frame.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    ack_d     = 1'b0;
    err_d     = mode_req_i && !req_ok;
    if (frame_boundary_i && (state_q == CTRL_PENDING)) begin
      active_d = pending_q;
      state_d  = CTRL_IDLE;
      ack_d    = 1'b1;
    end
    if (req_ok) begin
      pending_d = mode_sel_i;
      state_d   = CTRL_PENDING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CTRL_IDLE;
      pending_q <= MODE_W'(DEFAULT_MODE);
      active_q  <= MODE_W'(DEFAULT_MODE);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign mode_active_o = active_q;
  assign mode_next_o   = active_d;
  assign mode_busy_o   = (state_q == CTRL_PENDING);
  assign mode_ack_o    = ack_q;
  assign mode_err_o    = err_q;

endmodule

// File: rtl/vga_timing_multimode.sv
// rtl/vga_timing_multimode.sv - multi-mode VGA timing generator; VGA_SYNC_POLARITY_EN selects per-mode sync polarity
module vga_timing_multimode
  import vga_mode_pkg::*;
#(
  parameter int            NUM_MODES    = 3,
  parameter int            DEFAULT_MODE = 0,
  parameter int            MODE_W       = 2,
  parameter int            HW           = 11,
  parameter int            VW           = 10,
  parameter vga_mode_tbl_t MODE_TABLE   = VGA_MODE_TABLE_P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_req,
  input  logic [MODE_W-1:0] mode_sel,
  output logic [HW-1:0]     hcount,
  output logic [VW-1:0]     vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              hblnk,
  output logic              vblnk,
  output logic              line_start,
  output logic              frame_start,
  output logic [MODE_W-1:0] mode_active,
  output logic              mode_busy,
  output logic              mode_ack,
  output logic              mode_err
);

  localparam int HLIM = 1 << HW;
  localparam int VLIM = 1 << VW;

  logic [MODE_W-1:0] mode_next;
  logic              frame_boundary;
  logic              h_wrap, v_wrap;
  logic [HW-1:0]     h_last, hbs, hss, hse;
  logic [VW-1:0]     v_last, vbs, vss, vse;
  logic [HW-1:0]     hcount_q, hcount_d;
  logic [VW-1:0]     vcount_q, vcount_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              h_pol, v_pol;
  logic              hs_act, vs_act;
  logic [NUM_MODES-1:0] cfg_ok;

  vga_mode_ctrl #(
    .NUM_MODES   (NUM_MODES),
    .DEFAULT_MODE(DEFAULT_MODE),
    .MODE_W      (MODE_W)
  ) u_ctrl (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode_req_i      (mode_req),
    .mode_sel_i      (mode_sel),
    .frame_boundary_i(frame_boundary),
    .mode_active_o   (mode_active),
    .mode_next_o     (mode_next),
    .mode_busy_o     (mode_busy),
    .mode_ack_o      (mode_ack),
    .mode_err_o      (mode_err)
  );

  // Wrap points come from the mode in force; flags for the next pixel come
  // from the mode that will be in force, so a switch lands cleanly on (0,0).
  assign h_last = HW'(MODE_TABLE[mode_active].h_total - 16'd1);
  assign v_last = VW'(MODE_TABLE[mode_active].v_total - 16'd1);
  assign hbs    = MODE_TABLE[mode_next].h_blank_start[HW-1:0];
  assign hss    = MODE_TABLE[mode_next].h_sync_start[HW-1:0];
  assign hse    = MODE_TABLE[mode_next].h_sync_end[HW-1:0];
  assign vbs    = MODE_TABLE[mode_next].v_blank_start[VW-1:0];
  assign vss    = MODE_TABLE[mode_next].v_sync_start[VW-1:0];
  assign vse    = MODE_TABLE[mode_next].v_sync_end[VW-1:0];

`ifdef VGA_SYNC_POLARITY_EN
  localparam logic HS_IDLE = ~MODE_TABLE[DEFAULT_MODE].h_pol;
  localparam logic VS_IDLE = ~MODE_TABLE[DEFAULT_MODE].v_pol;
  assign h_pol = MODE_TABLE[mode_next].h_pol;
  assign v_pol = MODE_TABLE[mode_next].v_pol;
`else
  localparam logic HS_IDLE = 1'b0;
  localparam logic VS_IDLE = 1'b0;
  assign h_pol = 1'b1;
  assign v_pol = 1'b1;
`endif

  assign h_wrap         = (hcount_q == h_last);
  assign v_wrap         = (vcount_q == v_last);
  assign frame_boundary = h_wrap && v_wrap;

  always_comb begin
    hcount_d = h_wrap ? '0 : hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
    end
  end

  assign hs_act        = (hcount_d >= hss) && (hcount_d < hse);
  assign vs_act        = (vcount_d >= vss) && (vcount_d < vse);
  assign hsync_d       = hs_act ^ ~h_pol;
  assign vsync_d       = vs_act ^ ~v_pol;
  assign hblnk_d       = (hcount_d >= hbs);
  assign vblnk_d       = (vcount_d >= vbs);
  assign line_start_d  = (hcount_d == '0);
  assign frame_start_d = (hcount_d == '0) && (vcount_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= HS_IDLE;
      vsync_q       <= VS_IDLE;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  // Every table value in use must be representable at the counter widths.
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_cfg
    assign cfg_ok[m] = total_fits(MODE_TABLE[m].h_total, HLIM)
                    && val_below(MODE_TABLE[m].h_blank_start, HLIM)
                    && val_below(MODE_TABLE[m].h_sync_start, HLIM)
                    && val_below(MODE_TABLE[m].h_sync_end, HLIM)
                    && total_fits(MODE_TABLE[m].v_total, VLIM)
                    && val_below(MODE_TABLE[m].v_blank_start, VLIM)
                    && val_below(MODE_TABLE[m].v_sync_start, VLIM)
                    && val_below(MODE_TABLE[m].v_sync_end, VLIM);
  end

  always_ff @(posedge clk) begin
    assert (&cfg_ok) else $error("vga mode table value exceeds counter width");
  end

endmodule

// File: tb/tb_vga_timing_multimode.sv
// tb/tb_vga_timing_multimode.sv - directed bench: real table on dut0, scaled-down table on dut1 for frame-level handshake
module tb_vga_timing_multimode;
  import vga_mode_pkg::*;

`ifdef VGA_SYNC_POLARITY_EN
  localparam logic POL_EN = 1'b1;
`else
  localparam logic POL_EN = 1'b0;
`endif

  // Small table: frame lengths 72 (mode 0/3), 50 (mode 1), 32 (mode 2).
  localparam vga_mode_tbl_t SMALL_TBL = {
    vga_mode_t'{16'd12, 16'd8, 16'd9, 16'd11, 16'd6, 16'd4, 16'd4, 16'd5, 1'b0, 1'b0},
    vga_mode_t'{16'd8,  16'd5, 16'd6, 16'd7,  16'd4, 16'd3, 16'd3, 16'd4, 1'b0, 1'b0},
    vga_mode_t'{16'd10, 16'd6, 16'd7, 16'd9,  16'd5, 16'd3, 16'd3, 16'd4, 1'b1, 1'b1},
    vga_mode_t'{16'd12, 16'd8, 16'd9, 16'd11, 16'd6, 16'd4, 16'd4, 16'd5, 1'b0, 1'b0}
  };

  logic        clk;
  logic        rst0_n, rst1_n;
  logic        req0, req1;
  logic [1:0]  sel0, sel1;
  logic [10:0] d0_hc, d1_hc;
  logic [9:0]  d0_vc, d1_vc;
  logic        d0_hs, d0_vs, d0_hb, d0_vb, d0_ls, d0_fs, d0_busy, d0_ack, d0_err;
  logic        d1_hs, d1_vs, d1_hb, d1_vb, d1_ls, d1_fs, d1_busy, d1_ack, d1_err;
  logic [1:0]  d0_mode, d1_mode;
  int          n_cmp, n_bad, acks;

  vga_timing_multimode dut0 (
    .clk(clk), .rst_n(rst0_n), .mode_req(req0), .mode_sel(sel0),
    .hcount(d0_hc), .vcount(d0_vc), .hsync(d0_hs), .vsync(d0_vs),
    .hblnk(d0_hb), .vblnk(d0_vb), .line_start(d0_ls), .frame_start(d0_fs),
    .mode_active(d0_mode), .mode_busy(d0_busy), .mode_ack(d0_ack), .mode_err(d0_err)
  );

  vga_timing_multimode #(.MODE_TABLE(SMALL_TBL)) dut1 (
    .clk(clk), .rst_n(rst1_n), .mode_req(req1), .mode_sel(sel1),
    .hcount(d1_hc), .vcount(d1_vc), .hsync(d1_hs), .vsync(d1_vs),
    .hblnk(d1_hb), .vblnk(d1_vb), .line_start(d1_ls), .frame_start(d1_fs),
    .mode_active(d1_mode), .mode_busy(d1_busy), .mode_ack(d1_ack), .mode_err(d1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lvl(input logic act, input logic pol);
    return act ^ (POL_EN & ~pol);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (d1_ack) acks++;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; acks = 0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    req0 = 1'b0; sel0 = 2'd0; req1 = 1'b0; sel1 = 2'd0;
    run(3);

    chk("rst_hc",    32'(d0_hc), 32'd0);
    chk("rst_vc",    32'(d0_vc), 32'd0);
    chk("rst_hs",    32'(d0_hs), 32'(lvl(1'b0, 1'b0)));
    chk("rst_vs",    32'(d0_vs), 32'(lvl(1'b0, 1'b0)));
    chk("rst_hb",    32'(d0_hb), 32'd0);
    chk("rst_vb",    32'(d0_vb), 32'd0);
    chk("rst_ls",    32'(d0_ls), 32'd1);
    chk("rst_fs",    32'(d0_fs), 32'd1);
    chk("rst_mode",  32'(d0_mode), 32'd0);
    chk("rst_busy",  32'(d0_busy), 32'd0);
    chk("rst_ack",   32'(d0_ack), 32'd0);
    chk("rst_err",   32'(d0_err), 32'd0);

    // Real 1024x768 line timing on dut0.
    rst0_n = 1'b1;
    run(1023);
    chk("m0_hc1023", 32'(d0_hc), 32'd1023);
    chk("m0_hb1023", 32'(d0_hb), 32'd0);
    run(1);
    chk("m0_hb1024", 32'(d0_hb), 32'd1);
    run(23);
    chk("m0_hs1047", 32'(d0_hs), 32'(lvl(1'b0, 1'b0)));
    run(1);
    chk("m0_hs1048", 32'(d0_hs), 32'(lvl(1'b1, 1'b0)));
    run(135);
    chk("m0_hs1183", 32'(d0_hs), 32'(lvl(1'b1, 1'b0)));
    run(1);
    chk("m0_hs1184", 32'(d0_hs), 32'(lvl(1'b0, 1'b0)));
    run(159);
    chk("m0_hc1343", 32'(d0_hc), 32'd1343);
    chk("m0_ls1343", 32'(d0_ls), 32'd0);
    run(1);
    chk("m0_wrap_hc", 32'(d0_hc), 32'd0);
    chk("m0_wrap_vc", 32'(d0_vc), 32'd1);
    chk("m0_wrap_ls", 32'(d0_ls), 32'd1);
    chk("m0_wrap_fs", 32'(d0_fs), 32'd0);
    chk("m0_vb_l1",   32'(d0_vb), 32'd0);
    chk("m0_vs_l1",   32'(d0_vs), 32'(lvl(1'b0, 1'b0)));

    // Out-of-range select rejected.
    req0 = 1'b1; sel0 = 2'd3;
    run(1);
    req0 = 1'b0;
    chk("err_pulse", 32'(d0_err), 32'd1);
    chk("err_busy",  32'(d0_busy), 32'd0);
    chk("err_mode",  32'(d0_mode), 32'd0);
    run(1);
    chk("err_clear", 32'(d0_err), 32'd0);
    chk("err_hc",    32'(d0_hc), 32'd2);

    // Valid request then asynchronous reset mid-line while busy.
    req0 = 1'b1; sel0 = 2'd1;
    run(1);
    req0 = 1'b0;
    chk("d0_busy_set", 32'(d0_busy), 32'd1);
    run(497);
    chk("d0_hc500", 32'(d0_hc), 32'd500);
    #2 rst0_n = 1'b0;
    #1;
    chk("arst_hc",   32'(d0_hc), 32'd0);
    chk("arst_busy", 32'(d0_busy), 32'd0);
    chk("arst_fs",   32'(d0_fs), 32'd1);
    chk("arst_hs",   32'(d0_hs), 32'(lvl(1'b0, 1'b0)));
    run(1);
    rst0_n = 1'b1;
    run(5);
    chk("post_hc",   32'(d0_hc), 32'd5);
    chk("post_mode", 32'(d0_mode), 32'd0);
    chk("post_ack",  32'(d0_ack), 32'd0);
    chk("post_busy", 32'(d0_busy), 32'd0);

    // Frame-level handshake on dut1 (small table).
    chk("d1_rst_mode", 32'(d1_mode), 32'd0);
    chk("d1_rst_ls",   32'(d1_ls), 32'd1);
    rst1_n = 1'b1;
    acks = 0;
    run(5);
    chk("A5_hc", 32'(d1_hc), 32'd5);
    req1 = 1'b1; sel1 = 2'd2;
    run(1);
    req1 = 1'b0;
    chk("A6_busy", 32'(d1_busy), 32'd1);
    chk("A6_mode", 32'(d1_mode), 32'd0);
    run(42);
    chk("A48_vb", 32'(d1_vb), 32'd1);
    chk("A48_vs", 32'(d1_vs), 32'(lvl(1'b1, 1'b0)));
    run(23);
    chk("A71_vc",   32'(d1_vc), 32'd5);
    chk("A71_busy", 32'(d1_busy), 32'd1);
    chk("A71_ack",  32'(d1_ack), 32'd0);
    run(1);
    chk("B0_ack",  32'(d1_ack), 32'd1);
    chk("B0_mode", 32'(d1_mode), 32'd2);
    chk("B0_busy", 32'(d1_busy), 32'd0);
    chk("B0_fs",   32'(d1_fs), 32'd1);
    chk("B0_vc",   32'(d1_vc), 32'd0);
    run(5);
    chk("B5_hb", 32'(d1_hb), 32'd1);
    chk("B5_hs", 32'(d1_hs), 32'(lvl(1'b0, 1'b0)));
    run(1);
    chk("B6_hs", 32'(d1_hs), 32'(lvl(1'b1, 1'b0)));
    run(1);
    chk("B7_hs", 32'(d1_hs), 32'(lvl(1'b0, 1'b0)));
    chk("B7_hc", 32'(d1_hc), 32'd7);
    run(1);
    chk("B8_vc", 32'(d1_vc), 32'd1);
    chk("B8_ls", 32'(d1_ls), 32'd1);
    run(16);
    chk("B24_vb", 32'(d1_vb), 32'd1);
    chk("B24_vs", 32'(d1_vs), 32'(lvl(1'b1, 1'b0)));
    run(7);
    run(1);
    chk("C0_fs",  32'(d1_fs), 32'd1);
    chk("C0_ack", 32'(d1_ack), 32'd0);

    // Two requests in one frame: last wins, single ack.
    run(1);
    req1 = 1'b1; sel1 = 2'd1;
    run(1);
    sel1 = 2'd2;
    run(1);
    req1 = 1'b0;
    acks = 0;
    chk("C3_busy", 32'(d1_busy), 32'd1);
    run(28);
    run(1);
    chk("D0_ack",  32'(d1_ack), 32'd1);
    chk("D0_mode", 32'(d1_mode), 32'd2);
    run(3);
    chk("D3_acks", 32'(acks), 32'd1);

    // Invalid request while busy leaves the pending index alone.
    req1 = 1'b1; sel1 = 2'd0;
    run(1);
    chk("D4_busy", 32'(d1_busy), 32'd1);
    sel1 = 2'd3;
    run(1);
    req1 = 1'b0;
    chk("D5_err",  32'(d1_err), 32'd1);
    chk("D5_busy", 32'(d1_busy), 32'd1);
    run(1);
    chk("D6_err", 32'(d1_err), 32'd0);
    chk("D6_hc",  32'(d1_hc), 32'd6);
    run(25);
    run(1);
    chk("E0_ack",  32'(d1_ack), 32'd1);
    chk("E0_mode", 32'(d1_mode), 32'd0);

    // Request on the boundary cycle is deferred one full frame.
    run(71);
    chk("E71_hc", 32'(d1_hc), 32'd11);
    chk("E71_vc", 32'(d1_vc), 32'd5);
    req1 = 1'b1; sel1 = 2'd1;
    run(1);
    req1 = 1'b0;
    chk("F0_ack",  32'(d1_ack), 32'd0);
    chk("F0_mode", 32'(d1_mode), 32'd0);
    chk("F0_busy", 32'(d1_busy), 32'd1);
    chk("F0_hc",   32'(d1_hc), 32'd0);
    run(71);
    chk("F71_busy", 32'(d1_busy), 32'd1);
    run(1);
    chk("G0_ack",  32'(d1_ack), 32'd1);
    chk("G0_mode", 32'(d1_mode), 32'd1);
    run(7);
    chk("G7_hs", 32'(d1_hs), 32'(lvl(1'b1, 1'b1)));
    chk("G7_hb", 32'(d1_hb), 32'd1);
    run(2);
    chk("G9_hs", 32'(d1_hs), 32'(lvl(1'b0, 1'b1)));
    run(1);
    chk("G10_hc", 32'(d1_hc), 32'd0);
    chk("G10_vc", 32'(d1_vc), 32'd1);
    run(20);
    chk("G30_vb", 32'(d1_vb), 32'd1);
    chk("G30_vs", 32'(d1_vs), 32'(lvl(1'b1, 1'b1)));
    run(19);
    run(1);
    chk("H0_fs", 32'(d1_fs), 32'd1);
    chk("H0_vc", 32'(d1_vc), 32'd0);
    chk("d0_ack_end", 32'(d0_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
